// File: rtl/riscv_uop_pkg.sv
// Shared micro-op types for the RV32I decode stage and its consumers.
// Holds opcode/ALU enums, the uop_t bundle and the immediate generator.
package riscv_uop_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [6:0] {
    OPCODE_INVALID = 7'b0000000,
    OPCODE_LOAD    = 7'b0000011,
    OPCODE_OP_IMM  = 7'b0010011,
    OPCODE_AUIPC   = 7'b0010111,
    OPCODE_STORE   = 7'b0100011,
    OPCODE_OP      = 7'b0110011,
    OPCODE_LUI     = 7'b0110111,
    OPCODE_BRANCH  = 7'b1100011,
    OPCODE_JALR    = 7'b1100111,
    OPCODE_JAL     = 7'b1101111
  } riscv_opcode_t;

  // Encoding is {instr[30], funct3} zero-extended.
  typedef enum logic [9:0] {
    ALU_ADD  = 10'd0,
    ALU_SLL  = 10'd1,
    ALU_SLT  = 10'd2,
    ALU_SLTU = 10'd3,
    ALU_XOR  = 10'd4,
    ALU_SRL  = 10'd5,
    ALU_OR   = 10'd6,
    ALU_AND  = 10'd7,
    ALU_SUB  = 10'd8,
    ALU_SRA  = 10'd13
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SHAMT,
    IMM_NONE
  } imm_fmt_t;

  typedef struct packed {
    logic          valid;
    riscv_opcode_t opcode;
    alu_op_t       alu_op;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [31:0]   imm;
    logic          uses_rs1;
    logic          uses_rs2;
    logic          writes_rd;
    logic          is_immediate;
  } uop_t;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] i,
    input imm_fmt_t    f
  );
    logic [31:0] r;
    r = '0;
    unique case (f)
      IMM_I: r = {{20{i[31]}}, i[31:20]};
      IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: r = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_U: r = {i[31:12], 12'b0};
      IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      IMM_SHAMT: r = {27'b0, i[24:20]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_uop_decoder.sv
// Pure combinational RV32I instruction word to uop_t decoder.
// Illegal encodings produce an all-zero uop (valid=0, OPCODE_INVALID).
module riscv_uop_decoder
  import riscv_uop_pkg::*;
(
  input  logic [31:0] instr,
  output uop_t        uop
);

  riscv_opcode_t opc;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic          legal;
  logic          u1;
  logic          u2;
  logic          wr;
  logic          isimm;
  imm_fmt_t      fmt;
  alu_op_t       alu;

  assign opc = riscv_opcode_t'(instr[6:0]);
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    legal = (instr[1:0] == 2'b11);
    u1    = 1'b0;
    u2    = 1'b0;
    wr    = 1'b0;
    isimm = 1'b0;
    fmt   = IMM_NONE;
    alu   = ALU_ADD;
    unique case (opc)
      OPCODE_OP: begin
        u1  = 1'b1;
        u2  = 1'b1;
        wr  = 1'b1;
        alu = alu_op_t'({6'b0, instr[30], f3});
        if (!(f7 == 7'b0 ||
              (f7 == FUNCT7_ALT &&
               (f3 == 3'b000 || f3 == 3'b101))))
          legal = 1'b0;
      end
      OPCODE_OP_IMM: begin
        u1    = 1'b1;
        wr    = 1'b1;
        isimm = 1'b1;
        if (f3 == 3'b001) begin
          fmt = IMM_SHAMT;
          alu = ALU_SLL;
          if (f7 != 7'b0) legal = 1'b0;
        end else if (f3 == 3'b101) begin
          fmt = IMM_SHAMT;
          alu = instr[30] ? ALU_SRA : ALU_SRL;
          if (!(f7 == 7'b0 || f7 == FUNCT7_ALT))
            legal = 1'b0;
        end else begin
          fmt = IMM_I;
          alu = alu_op_t'({7'b0, f3});
        end
      end
      OPCODE_LOAD: begin
        u1    = 1'b1;
        wr    = 1'b1;
        isimm = 1'b1;
        fmt   = IMM_I;
      end
      OPCODE_STORE: begin
        u1    = 1'b1;
        u2    = 1'b1;
        isimm = 1'b1;
        fmt   = IMM_S;
      end
      OPCODE_BRANCH: begin
        u1  = 1'b1;
        u2  = 1'b1;
        alu = ALU_SUB;
        fmt = IMM_B;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        wr    = 1'b1;
        isimm = 1'b1;
        fmt   = IMM_U;
      end
      OPCODE_JAL: begin
        wr    = 1'b1;
        isimm = 1'b1;
        fmt   = IMM_J;
      end
      OPCODE_JALR: begin
        u1    = 1'b1;
        wr    = 1'b1;
        isimm = 1'b1;
        fmt   = IMM_I;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    uop = '0;
    if (legal) begin
      uop.valid        = 1'b1;
      uop.opcode       = opc;
      uop.alu_op       = alu;
      uop.imm          = imm_gen(instr, fmt);
      uop.uses_rs1     = u1;
      uop.uses_rs2     = u2;
      uop.writes_rd    = wr && (instr[11:7] != 5'd0);
      uop.is_immediate = isimm;
      uop.rs1          = u1 ? instr[19:15] : 5'd0;
      uop.rs2          = u2 ? instr[24:20] : 5'd0;
      uop.rd           = uop.writes_rd ? instr[11:7] : 5'd0;
    end
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: decoder feeding a registered 2-entry skid buffer
// with valid/ready on both sides and synchronous flush.
module riscv_decode_stage
  import riscv_uop_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output uop_t            out_uop_o,
  output logic [XLEN-1:0] out_pc_o
);

  uop_t            dec_uop;
  logic            main_v;
  uop_t            main_uop;
  logic [XLEN-1:0] main_pc;
  logic            skid_v;
  uop_t            skid_uop;
  logic [XLEN-1:0] skid_pc;
  logic            push;
  logic            pop;

  riscv_uop_decoder u_dec (
    .instr (in_instr_i),
    .uop   (dec_uop)
  );

  assign in_ready_o  = !skid_v;
  assign out_valid_o = main_v;
  assign out_uop_o   = main_uop;
  assign out_pc_o    = main_pc;
  assign push = in_valid_i && !skid_v;
  assign pop  = main_v && out_ready_i;

  // Skid only fills while main is stalled, so push never
  // coincides with a full skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v   <= 1'b0;
      main_uop <= '0;
      main_pc  <= '0;
      skid_v   <= 1'b0;
      skid_uop <= '0;
      skid_pc  <= '0;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v && pop) begin
      main_uop <= skid_uop;
      main_pc  <= skid_pc;
      skid_v   <= 1'b0;
    end else if (push && (pop || !main_v)) begin
      main_v   <= 1'b1;
      main_uop <= dec_uop;
      main_pc  <= in_pc_i;
    end else if (push) begin
      skid_v   <= 1'b1;
      skid_uop <= dec_uop;
      skid_pc  <= in_pc_i;
    end else if (pop) begin
      main_v <= 1'b0;
    end
  end

endmodule
